axis_dma_read_status_demux: RTL and testbench
=============================================

Name: axis_dma_read_status_demux

Overview:
- Return path for the merged DMA read-descriptor stream, where the issuing side marks each descriptor's tag MSB as 1 = re client, 0 = cu client.
- This block takes the single DMA engine read-status stream (tag width DMA_TAG_WIDTH+1, no backpressure), strips the MSB, and routes the status to the cu or re client.
- Each client has its own output FIFO with ready/valid handshake.
- Per-client outstanding-request counters are kept from a monitor of the issue-side handshake, and sticky error flags are raised for overflow and unexpected completions.

Parameters:
- DMA_TAG_WIDTH, 16, client tag width; the engine-side tag is DMA_TAG_WIDTH+1 bits.
- ERROR_WIDTH, 4, status error code width.
- FIFO_DEPTH, 8, entries per client FIFO; must be a power of two and at least 2.
- CNT_WIDTH, 8, outstanding counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_axis_dma_read_desc_status_tag  in  DMA_TAG_WIDTH+1  engine status tag; MSB is the client select.
- s_axis_dma_read_desc_status_error  in  ERROR_WIDTH  engine error code.
- s_axis_dma_read_desc_status_valid  in  1  status strobe; there is no ready signal.
- mon_dma_read_desc_fire  in  1  issue-side descriptor handshake occurred (valid&&ready).
- mon_dma_read_desc_sel  in  1  tag MSB of the issued descriptor.
- m_axis_cu_dma_read_status_tag  out  DMA_TAG_WIDTH  cu tag.
- m_axis_cu_dma_read_status_error  out  ERROR_WIDTH  cu error.
- m_axis_cu_dma_read_status_valid  out  1  cu status valid.
- m_axis_cu_dma_read_status_ready  in  1  cu accept.
- m_axis_re_dma_read_status_tag  out  DMA_TAG_WIDTH  re tag.
- m_axis_re_dma_read_status_error  out  ERROR_WIDTH  re error.
- m_axis_re_dma_read_status_valid  out  1  re status valid.
- m_axis_re_dma_read_status_ready  in  1  re accept.
- cu_outstanding  out  CNT_WIDTH  cu in-flight reads.
- re_outstanding  out  CNT_WIDTH  re in-flight reads.
- stat_cu_overflow  out  1  sticky: cu status dropped.
- stat_re_overflow  out  1  sticky: re status dropped.
- stat_cu_unexpected  out  1  sticky: cu status arrived with cu_outstanding == 0.
- stat_re_unexpected  out  1  sticky: re status arrived with re_outstanding == 0.

Behaviour:
- Reset: a synchronous rst clears all FIFO pointers and fill counts, both counters and all sticky flags.
  - All outputs are 0 in the cycle after rst is sampled; valid outputs are 0.
  - Reset mid-operation discards all queued entries.
- Routing: when status_valid is high, tag[DMA_TAG_WIDTH] selects re (1) or cu (0).
  - Lower DMA_TAG_WIDTH bits and error are pushed unmodified into the selected FIFO.
  - Nonzero error is forwarded, not interpreted.
- Latency: status strobe in cycle N gives valid at the output in cycle N+1, provided the FIFO was empty.
  - Outputs are driven from registers or FIFO storage, never combinationally from s_axis inputs.
- Output handshake:
  - valid = FIFO non-empty. Head data is held stable while valid && !ready.
  - Pop on valid && ready.
  - Back-to-back pops give one entry per cycle.
- FIFO full:
  - Push when full and no pop in the same cycle: the entry is dropped and the overflow sticky is set. Contents are unchanged.
  - Push when full with a pop in the same cycle: the push is accepted and the fill count is unchanged.
- Empty: valid = 0 and tag/error hold their last values.
  - Push into an empty FIFO with ready = 1 gives exactly one valid cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; the fill count is log2(FIFO_DEPTH)+1 bits.
- Ordering: FIFO order is preserved per client. There is no ordering relation between the cu and re outputs.
- Outstanding counters, per client, applied independently:
  - +1 on mon_fire with a matching sel; -1 on status_valid with a matching MSB.
  - Both in the same cycle: unchanged.
  - Increment at all-ones saturates (holds).
  - Decrement at 0 holds at 0 and sets the unexpected sticky. The status is still forwarded.
- Sticky flags clear only on rst.

Test Plan:
1. Issue tags re 0x0005 and cu 0x0003 (mon sel=1, then sel=0); engine returns {1,0x0005} err 0, then {0,0x0003} err 2; both readys high.
   - re output: tag 0x0005 err 0, valid one cycle after its strobe.
   - cu output: tag 0x0003 err 2, one cycle after its strobe.
   - Counters go 1 → 0, no sticky flags set.
2. cu ready low; 8 cu statuses with tags 0..7 are issued and returned.
   - cu_valid stays high with head tag 0 stable.
   - Raising ready gives tags 0..7 on consecutive cycles; no overflow.
3. cu FIFO full with ready low; a 9th status with tag 8 arrives.
   - It is dropped and stat_cu_overflow = 1.
   - Repeat with ready high in that cycle: tag 8 is accepted and no flag is set.
4. re_outstanding = 0 and status {1,0x0010} arrives.
   - It is forwarded on re, stat_re_unexpected = 1, re_outstanding stays 0.
5. mon_fire with sel=0 in the same cycle as status {0,x}, with cu_outstanding = 3.
   - cu_outstanding remains 3.
   - Saturation check: 255 fires take the counter to 255; a further fire holds at 255.
6. Assert rst with 4 entries queued in each FIFO.
   - Next cycle both valids are 0, counters are 0 and flags are 0.
   - A status after reset is delivered with 1-cycle latency.

Source files
------------

// File: rtl/axis_dma_read_status_demux.sv
// Read-status return demux: routes engine status by tag MSB (1 = re, 0 = cu) into
// per-client FIFOs, tracks per-client outstanding reads and raises sticky error flags.
module axis_dma_read_status_demux #(
  parameter int unsigned DMA_TAG_WIDTH = 16,
  parameter int unsigned ERROR_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DMA_TAG_WIDTH:0]   s_axis_dma_read_desc_status_tag,
  input  logic [ERROR_WIDTH-1:0]   s_axis_dma_read_desc_status_error,
  input  logic                     s_axis_dma_read_desc_status_valid,
  input  logic                     mon_dma_read_desc_fire,
  input  logic                     mon_dma_read_desc_sel,
  output logic [DMA_TAG_WIDTH-1:0] m_axis_cu_dma_read_status_tag,
  output logic [ERROR_WIDTH-1:0]   m_axis_cu_dma_read_status_error,
  output logic                     m_axis_cu_dma_read_status_valid,
  input  logic                     m_axis_cu_dma_read_status_ready,
  output logic [DMA_TAG_WIDTH-1:0] m_axis_re_dma_read_status_tag,
  output logic [ERROR_WIDTH-1:0]   m_axis_re_dma_read_status_error,
  output logic                     m_axis_re_dma_read_status_valid,
  input  logic                     m_axis_re_dma_read_status_ready,
  output logic [CNT_WIDTH-1:0]     cu_outstanding,
  output logic [CNT_WIDTH-1:0]     re_outstanding,
  output logic                     stat_cu_overflow,
  output logic                     stat_re_overflow,
  output logic                     stat_cu_unexpected,
  output logic                     stat_re_unexpected
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = DMA_TAG_WIDTH + ERROR_WIDTH;

  localparam logic [PtrW-1:0]      PtrOne   = (PtrW)'(1);
  localparam logic [PtrW:0]        FillOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]        FillFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntOne   = (CNT_WIDTH)'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

  // Index 0 is the cu client, index 1 the re client.
  logic [EntryW-1:0]    mem_q  [2][FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q [2];
  logic [PtrW-1:0]      rptr_q [2];
  logic [PtrW:0]        fill_q [2];
  logic [EntryW-1:0]    last_q [2];
  logic [CNT_WIDTH-1:0] cnt_q  [2];
  logic [1:0]           ovf_q;
  logic [1:0]           unexp_q;

  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        inc;
  logic [1:0]        valid;
  logic [1:0]        full;
  logic [1:0]        pop;
  logic [1:0]        accept;
  logic [EntryW-1:0] head [2];
  logic [EntryW-1:0] in_entry;

  assign ready    = {m_axis_re_dma_read_status_ready, m_axis_cu_dma_read_status_ready};
  assign in_entry = {s_axis_dma_read_desc_status_tag[DMA_TAG_WIDTH-1:0],
                     s_axis_dma_read_desc_status_error};

  // Per-client push/pop decode; head falls back to the last shown entry when empty.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      push[c]   = s_axis_dma_read_desc_status_valid &&
                  (s_axis_dma_read_desc_status_tag[DMA_TAG_WIDTH] == (c == 1));
      inc[c]    = mon_dma_read_desc_fire && (mon_dma_read_desc_sel == (c == 1));
      valid[c]  = (fill_q[c] != '0);
      full[c]   = (fill_q[c] == FillFull);
      pop[c]    = valid[c] && ready[c];
      // A full FIFO still takes a push when its head leaves in the same cycle.
      accept[c] = push[c] && (!full[c] || pop[c]);
      head[c]   = valid[c] ? mem_q[c][rptr_q[c]] : last_q[c];
    end
  end

  // FIFO storage; contents need no reset since fill count gates visibility.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (accept[c]) mem_q[c][wptr_q[c]] <= in_entry;
    end
  end

  // Pointers, fill counts, held output, outstanding counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        fill_q[c] <= '0;
        last_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      ovf_q   <= '0;
      unexp_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (accept[c]) wptr_q[c] <= wptr_q[c] + PtrOne;
        if (pop[c])    rptr_q[c] <= rptr_q[c] + PtrOne;
        case ({accept[c], pop[c]})
          2'b10:   fill_q[c] <= fill_q[c] + FillOne;
          2'b01:   fill_q[c] <= fill_q[c] - FillOne;
          default: fill_q[c] <= fill_q[c];
        endcase
        if (valid[c]) last_q[c] <= mem_q[c][rptr_q[c]];
        if (push[c] && full[c] && !pop[c]) ovf_q[c] <= 1'b1;
        // Simultaneous issue and completion cancel out.
        if (inc[c] && !push[c] && (cnt_q[c] != CntMax)) cnt_q[c] <= cnt_q[c] + CntOne;
        if (push[c] && !inc[c]) begin
          if (cnt_q[c] == '0) unexp_q[c] <= 1'b1;
          else                cnt_q[c]   <= cnt_q[c] - CntOne;
        end
      end
    end
  end

  assign m_axis_cu_dma_read_status_valid = valid[0];
  assign m_axis_cu_dma_read_status_tag   = head[0][EntryW-1:ERROR_WIDTH];
  assign m_axis_cu_dma_read_status_error = head[0][ERROR_WIDTH-1:0];
  assign m_axis_re_dma_read_status_valid = valid[1];
  assign m_axis_re_dma_read_status_tag   = head[1][EntryW-1:ERROR_WIDTH];
  assign m_axis_re_dma_read_status_error = head[1][ERROR_WIDTH-1:0];

  assign cu_outstanding     = cnt_q[0];
  assign re_outstanding     = cnt_q[1];
  assign stat_cu_overflow   = ovf_q[0];
  assign stat_re_overflow   = ovf_q[1];
  assign stat_cu_unexpected = unexp_q[0];
  assign stat_re_unexpected = unexp_q[1];

endmodule

// File: tb/tb_axis_dma_read_status_demux.sv
// Self-checking bench for axis_dma_read_status_demux: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_axis_dma_read_status_demux;

  localparam int TW    = 16;
  localparam int EW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic          clk;
  logic          rst;
  logic [TW:0]   s_tag;
  logic [EW-1:0] s_err;
  logic          s_valid;
  logic          mon_fire;
  logic          mon_sel;
  logic [TW-1:0] cu_tag, re_tag;
  logic [EW-1:0] cu_err, re_err;
  logic          cu_valid, re_valid;
  logic          cu_ready, re_ready;
  logic [CW-1:0] cu_out, re_out;
  logic          cu_ovf, re_ovf, cu_unx, re_unx;

  int checks;
  int failures;

  // Reference model: one queue of {tag, err} per client (0 = cu, 1 = re).
  logic [TW+EW-1:0] mq [2][$];
  logic [TW+EW-1:0] mlast [2];
  int               mcnt [2];
  bit               movf [2];
  bit               munx [2];

  axis_dma_read_status_demux #(
    .DMA_TAG_WIDTH(TW), .ERROR_WIDTH(EW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk                               (clk),
    .rst                               (rst),
    .s_axis_dma_read_desc_status_tag   (s_tag),
    .s_axis_dma_read_desc_status_error (s_err),
    .s_axis_dma_read_desc_status_valid (s_valid),
    .mon_dma_read_desc_fire            (mon_fire),
    .mon_dma_read_desc_sel             (mon_sel),
    .m_axis_cu_dma_read_status_tag     (cu_tag),
    .m_axis_cu_dma_read_status_error   (cu_err),
    .m_axis_cu_dma_read_status_valid   (cu_valid),
    .m_axis_cu_dma_read_status_ready   (cu_ready),
    .m_axis_re_dma_read_status_tag     (re_tag),
    .m_axis_re_dma_read_status_error   (re_err),
    .m_axis_re_dma_read_status_valid   (re_valid),
    .m_axis_re_dma_read_status_ready   (re_ready),
    .cu_outstanding                    (cu_out),
    .re_outstanding                    (re_out),
    .stat_cu_overflow                  (cu_ovf),
    .stat_re_overflow                  (re_ovf),
    .stat_cu_unexpected                (cu_unx),
    .stat_re_unexpected                (re_unx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the model by the inputs the DUT is about to sample.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      bit rdy, push, inc, pop;
      int sz;
      rdy  = (c == 1) ? re_ready : cu_ready;
      push = s_valid && (s_tag[TW] == (c == 1));
      inc  = mon_fire && (mon_sel == (c == 1));
      if (rst) begin
        mq[c].delete();
        mlast[c] = '0;
        mcnt[c]  = 0;
        movf[c]  = 0;
        munx[c]  = 0;
      end else begin
        sz = mq[c].size();
        if (sz > 0) mlast[c] = mq[c][0];
        pop = (sz > 0) && rdy;
        if (pop) void'(mq[c].pop_front());
        if (push) begin
          if (sz < DEPTH || pop) mq[c].push_back({s_tag[TW-1:0], s_err});
          else movf[c] = 1;
        end
        if (inc && !push && mcnt[c] < 255) mcnt[c]++;
        if (push && !inc) begin
          if (mcnt[c] == 0) munx[c] = 1;
          else mcnt[c]--;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fire_n(input logic sel, input int n);
    for (int i = 0; i < n; i++) begin
      mon_fire = 1'b1;
      mon_sel  = sel;
      tick();
    end
    mon_fire = 1'b0;
  endtask

  task automatic push_status(input logic sel, input logic [TW-1:0] tag, input logic [EW-1:0] err);
    s_valid = 1'b1;
    s_tag   = {sel, tag};
    s_err   = err;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cu_valid, re_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_valid: got %b want 00", {cu_valid, re_valid});
    end
    checks++;
    if ({cu_tag, cu_err, re_tag, re_err} !== '0) begin
      failures++;
      $display("FAIL reset_data: got cu %h/%h re %h/%h want 0", cu_tag, cu_err, re_tag, re_err);
    end
    checks++;
    if ({cu_out, re_out, cu_ovf, re_ovf, cu_unx, re_unx} !== '0) begin
      failures++;
      $display("FAIL reset_stat: got cnt %0d/%0d flags %b want 0", cu_out, re_out,
               {cu_ovf, re_ovf, cu_unx, re_unx});
    end
  endtask

  task automatic test_basic();
    do_reset();
    cu_ready = 1'b1;
    re_ready = 1'b1;
    fire_n(1'b1, 1);
    fire_n(1'b0, 1);
    checks++;
    if (cu_out !== 8'd1 || re_out !== 8'd1) begin
      failures++;
      $display("FAIL basic_issue_cnt: got cu %0d re %0d want 1 1", cu_out, re_out);
    end
    push_status(1'b1, 16'h0005, 4'h0);
    checks++;
    if ({re_valid, re_tag, re_err, cu_valid} !== {1'b1, 16'h0005, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL basic_re_out: got v%b tag %h err %h cu_v %b want v1 0005 0 0",
               re_valid, re_tag, re_err, cu_valid);
    end
    push_status(1'b0, 16'h0003, 4'h2);
    checks++;
    if ({cu_valid, cu_tag, cu_err} !== {1'b1, 16'h0003, 4'h2}) begin
      failures++;
      $display("FAIL basic_cu_out: got v%b tag %h err %h want v1 0003 2", cu_valid, cu_tag, cu_err);
    end
    checks++;
    if (re_valid !== 1'b0 || re_tag !== 16'h0005) begin
      failures++;
      $display("FAIL basic_re_hold: got v%b tag %h want v0 0005", re_valid, re_tag);
    end
    tick();
    checks++;
    if ({cu_valid, cu_out, re_out, cu_ovf, re_ovf, cu_unx, re_unx} !== '0) begin
      failures++;
      $display("FAIL basic_end: got cu_v %b cnt %0d/%0d flags %b want all 0", cu_valid, cu_out,
               re_out, {cu_ovf, re_ovf, cu_unx, re_unx});
    end
  endtask

  task automatic test_fill_drain();
    int bad;
    do_reset();
    cu_ready = 1'b0;
    fire_n(1'b0, 8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      push_status(1'b0, TW'(i), EW'(i));
      if (cu_valid !== 1'b1 || cu_tag !== 16'h0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fill_head_stable: %0d cycles with head not v1 tag 0 (got v%b tag %h)", bad,
               cu_valid, cu_tag);
    end
    cu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({cu_valid, cu_tag, cu_err} !== {1'b1, TW'(i), EW'(i)}) begin
        failures++;
        $display("FAIL drain_%0d: got v%b tag %h err %h want v1 %h %h", i, cu_valid, cu_tag,
                 cu_err, TW'(i), EW'(i));
      end
      tick();
    end
    checks++;
    if ({cu_valid, cu_ovf, cu_unx, cu_out} !== '0) begin
      failures++;
      $display("FAIL drain_end: got v%b ovf %b unx %b cnt %0d want 0", cu_valid, cu_ovf, cu_unx,
               cu_out);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cu_ready = 1'b0;
    fire_n(1'b0, 9);
    for (int i = 0; i < 8; i++) push_status(1'b0, TW'(i), 4'h0);
    push_status(1'b0, 16'h0008, 4'h0);
    checks++;
    if (cu_ovf !== 1'b1 || cu_unx !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drop_flag: got ovf %b unx %b want 1 0", cu_ovf, cu_unx);
    end
    cu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cu_valid !== 1'b1 || cu_tag !== TW'(i)) begin
        failures++;
        $display("FAIL ovf_drain_%0d: got v%b tag %h want v1 %h", i, cu_valid, cu_tag, TW'(i));
      end
      tick();
    end
    checks++;
    if (cu_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_dropped_entry: got v%b tag %h want v0", cu_valid, cu_tag);
    end
    // Full with a simultaneous pop: the push must be accepted.
    do_reset();
    cu_ready = 1'b0;
    fire_n(1'b0, 9);
    for (int i = 0; i < 8; i++) push_status(1'b0, TW'(i), 4'h0);
    cu_ready = 1'b1;
    push_status(1'b0, 16'h0008, 4'h0);
    checks++;
    if (cu_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pop_push_flag: got ovf %b want 0", cu_ovf);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (cu_valid !== 1'b1 || cu_tag !== TW'(i)) begin
        failures++;
        $display("FAIL ovf_pop_drain_%0d: got v%b tag %h want v1 %h", i, cu_valid, cu_tag, TW'(i));
      end
      tick();
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    re_ready = 1'b1;
    push_status(1'b1, 16'h0010, 4'h0);
    checks++;
    if ({re_valid, re_tag, re_unx, re_out, cu_unx} !== {1'b1, 16'h0010, 1'b1, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL unexpected: got v%b tag %h unx %b cnt %0d cu_unx %b want v1 0010 1 0 0",
               re_valid, re_tag, re_unx, re_out, cu_unx);
    end
  endtask

  task automatic test_counters();
    do_reset();
    cu_ready = 1'b1;
    fire_n(1'b0, 3);
    mon_fire = 1'b1;
    mon_sel  = 1'b0;
    push_status(1'b0, 16'h0077, 4'h1);
    mon_fire = 1'b0;
    checks++;
    if (cu_out !== 8'd3 || cu_unx !== 1'b0 || cu_valid !== 1'b1) begin
      failures++;
      $display("FAIL cnt_both: got cnt %0d unx %b v%b want 3 0 1", cu_out, cu_unx, cu_valid);
    end
    do_reset();
    fire_n(1'b0, 255);
    checks++;
    if (cu_out !== 8'd255 || re_out !== 8'd0) begin
      failures++;
      $display("FAIL cnt_255: got cu %0d re %0d want 255 0", cu_out, re_out);
    end
    fire_n(1'b0, 1);
    checks++;
    if (cu_out !== 8'd255) begin
      failures++;
      $display("FAIL cnt_sat: got %0d want 255", cu_out);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    cu_ready = 1'b0;
    re_ready = 1'b0;
    fire_n(1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      push_status(1'b1, TW'(16'h100 + i), 4'h3);
      push_status(1'b0, TW'(16'h200 + i), 4'h4);
    end
    checks++;
    if ({cu_valid, re_valid, cu_unx} !== 3'b111) begin
      failures++;
      $display("FAIL midop_pre: got cu_v %b re_v %b cu_unx %b want 1 1 1", cu_valid, re_valid,
               cu_unx);
    end
    do_reset();
    checks++;
    if ({cu_valid, re_valid, cu_out, re_out, cu_ovf, re_ovf, cu_unx, re_unx} !== '0) begin
      failures++;
      $display("FAIL midop_reset: got v %b%b cnt %0d/%0d flags %b want all 0", cu_valid, re_valid,
               cu_out, re_out, {cu_ovf, re_ovf, cu_unx, re_unx});
    end
    cu_ready = 1'b1;
    re_ready = 1'b1;
    push_status(1'b0, 16'h0abc, 4'h1);
    checks++;
    if ({cu_valid, cu_tag, cu_err, re_valid} !== {1'b1, 16'h0abc, 4'h1, 1'b0}) begin
      failures++;
      $display("FAIL midop_after: got v%b tag %h err %h re_v %b want v1 0abc 1 0", cu_valid,
               cu_tag, cu_err, re_valid);
    end
    tick();
    checks++;
    if (cu_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_one_cycle: got v%b want 0", cu_valid);
    end
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rdy_pct  = (n < 1500) ? 15 : 80;
      mon_fire = ($urandom_range(99) < 45);
      mon_sel  = 1'($urandom);
      s_valid  = ($urandom_range(99) < 50);
      s_tag    = (TW + 1)'($urandom);
      s_err    = EW'($urandom);
      cu_ready = ($urandom_range(99) < rdy_pct);
      re_ready = ($urandom_range(99) < rdy_pct);
      tick();
      for (int c = 0; c < 2; c++) begin
        logic [TW+EW:0] exp_o, got_o;
        logic [CW+1:0]  exp_s, got_s;
        exp_o = {mq[c].size() != 0, (mq[c].size() != 0) ? mq[c][0] : mlast[c]};
        got_o = (c == 1) ? {re_valid, re_tag, re_err} : {cu_valid, cu_tag, cu_err};
        exp_s = {CW'(mcnt[c]), movf[c], munx[c]};
        got_s = (c == 1) ? {re_out, re_ovf, re_unx} : {cu_out, cu_ovf, cu_unx};
        checks++;
        if (got_o !== exp_o) begin
          failures++;
          $display("FAIL rand_out c%0d cyc %0d: got %h want %h", c, n, got_o, exp_o);
        end
        checks++;
        if (got_s !== exp_s) begin
          failures++;
          $display("FAIL rand_stat c%0d cyc %0d: got %h want %h", c, n, got_s, exp_s);
        end
      end
    end
    s_valid  = 1'b0;
    mon_fire = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    s_tag    = '0;
    s_err    = '0;
    s_valid  = 1'b0;
    mon_fire = 1'b0;
    mon_sel  = 1'b0;
    cu_ready = 1'b0;
    re_ready = 1'b0;
    test_reset();
    test_basic();
    test_fill_drain();
    test_overflow();
    test_unexpected();
    test_counters();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
